jump_motion_ctl: RTL
====================

Name: jump_motion_ctl

Overview:
Parametrised player-motion controller for the Jump King game and the successor to the fixed-constant rectangle controller. It converts the debounced key levels key_space, key_left and key_right into on-screen coordinates value_x and value_y for the rectangle/sprite draw stage. The physics tick rate, playfield bounds, gravity, walk speed and jump strength are all parameters. New relative to the current controller:
- charged jumps with saturation;
- directional jumps;
- wall bounce;
- ceiling clamp.

Parameters:
W, 12, coordinate width of value_x/value_y
TICK_DIV, 40000, clk cycles per physics tick (1 kHz at 40 MHz)
X_MIN, 0, left wall (leftmost legal x)
X_MAX, 1000, right wall (rightmost legal x)
Y_MIN, 0, ceiling (smallest legal y)
GROUND_Y, 700, floor y; y grows downward
X_INIT, 500, x after reset
GRAVITY, 1, vy decrement per air tick
WALK_STEP, 2, x step per tick while walking
CHARGE_MAX, 40, saturation limit of charge; vy at launch = charge
JUMP_VX, 3, horizontal speed magnitude of a directional jump

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_space  in  1  jump key level, high = held
key_left  in  1  left key level
key_right  in  1  right key level
value_x  out  W  player x
value_y  out  W  player y
state  out  2  0 = GROUND, 1 = CHARGE, 2 = AIR
charge_level  out  8  current charge (0 outside CHARGE)
tick  out  1  one-cycle physics-tick strobe

Behaviour:
- Reset (rst high at a clk edge) overrides everything, including mid-jump:
  - tick counter = 0, tick = 0;
  - state = GROUND, value_x = X_INIT, value_y = GROUND_Y;
  - vx = vy = 0, charge = 0, dir = 0.
- Tick generation:
  - the counter runs 0..TICK_DIV-1 and wraps to 0;
  - tick is registered and high for one cycle when the counter equals TICK_DIV-1;
  - the first tick comes TICK_DIV cycles after reset is released.
- All state, position and velocity updates happen only on clk edges where tick = 1. Keys are sampled only then, so a key pulse shorter than one tick period may be missed.
- dir is derived from the keys: left only gives -1, right only gives +1, neither or both gives 0.
- GROUND state:
  - key_space = 1: go to CHARGE, charge = 1; no walk on this tick.
  - otherwise: x += dir*WALK_STEP, clamped to [X_MIN, X_MAX]; y stays at GROUND_Y.
- CHARGE state:
  - space still held: charge = min(charge+1, CHARGE_MAX); dir_latch = dir, updated every tick. Position is frozen.
  - space released: go to AIR with vy = +charge (upward), vx = dir_latch*JUMP_VX, charge = 0.
- AIR state (keys ignored), each tick, in this order:
  1. yn = y - vy.
  2. Ceiling: if yn < Y_MIN then y = Y_MIN and vy = 0.
  3. Landing: else if yn >= GROUND_Y then y = GROUND_Y, vx = vy = 0, state = GROUND.
  4. Otherwise y = yn and vy = vy - GRAVITY.
  5. xn = x + vx. If xn < X_MIN, x = X_MIN and vx = -vx. If xn > X_MAX, x = X_MAX and vx = -vx. Otherwise x = xn.
  - Landing and a wall hit on the same tick: both apply, and the final vx = 0.
- Arithmetic:
  - vx and vy are signed, W+2 bits;
  - yn and xn are computed signed in W+2 bits, so there is no wrap below 0 or above 2^W;
  - outputs are the unsigned low W bits of the clamped values.
- charge_level mirrors charge (zero-extended or truncated to 8 bits). state and outputs are registered, with one-tick latency from the sampled key to the updated position.

Test Plan:
(All scenarios use TICK_DIV=4 and defaults otherwise.)
1. Reset / tick: hold rst 3 cycles, then release.
   -> value_x = 500, value_y = 700, state = 0.
   -> First tick 4 cycles after release, then exactly one tick every 4 cycles.
2. Walk and clamp: hold key_right for 260 ticks.
   -> x rises by 2 per tick and stops at 1000.
   -> Both keys held: x is unchanged.
   -> Left from x=1 gives 0.
3. Vertical jump: hold space for 5 ticks, then release.
   -> charge_level 1..5, state 1.
   -> Air y sequence: 695, 691, 688, 686, 685, 685, 686, 688, 691, 695, then 700 with state 0.
4. Saturation: hold space for 100 ticks.
   -> charge_level stops at 40.
   -> Launch with vy = 40; apex y = 700 - 820 → clamps to 0 with vy = 0, then falls back to 700.
5. Directional jump with wall bounce: start at x=995, hold right+space for 3 ticks, release.
   -> x = 998, then 1000 with vx = -3, then 997, 994, ...
   -> On landing vx = 0 and x holds.
6. Reset mid-air: assert rst during AIR.
   -> Next edge: x = 500, y = 700, state = 0, charge_level = 0, tick counter restarts.

Source files
------------

// File: rtl/jump_motion_ctl.sv
// jump_motion_ctl: player-motion controller for the Jump King game.
//
// Turns the debounced key levels into on-screen coordinates for the draw stage.
// All motion runs on an internal physics tick. The controller supports walking
// with wall clamping, charged jumps that saturate at CHARGE_MAX, and directional
// jumps. Airborne motion also handles wall bounce, a ceiling clamp and landing.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   key_space    jump key level (high = held)
//   key_left     left key level
//   key_right    right key level
//   value_x      player x (low W bits)
//   value_y      player y (low W bits, grows downward)
//   state        0 = GROUND, 1 = CHARGE, 2 = AIR
//   charge_level current charge, 0 outside CHARGE
//   tick         one-cycle physics-tick strobe
module jump_motion_ctl #(
    parameter int unsigned W          = 12,
    parameter int unsigned TICK_DIV   = 40000,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 1000,
    parameter int unsigned Y_MIN      = 0,
    parameter int unsigned GROUND_Y   = 700,
    parameter int unsigned X_INIT     = 500,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned WALK_STEP  = 2,
    parameter int unsigned CHARGE_MAX = 40,
    parameter int unsigned JUMP_VX    = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_space,
    input  logic         key_left,
    input  logic         key_right,
    output logic [W-1:0] value_x,
    output logic [W-1:0] value_y,
    output logic [1:0]   state,
    output logic [7:0]   charge_level,
    output logic         tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned VW   = W + 2;

    // Positions, velocities and charge share one signed width so that intermediate
    // results never wrap below 0 or above 2^W.
    typedef logic signed [VW-1:0] sval_t;

    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    localparam sval_t XMin      = sval_t'(X_MIN);
    localparam sval_t XMax      = sval_t'(X_MAX);
    localparam sval_t YMin      = sval_t'(Y_MIN);
    localparam sval_t GroundY   = sval_t'(GROUND_Y);
    localparam sval_t XInit     = sval_t'(X_INIT);
    localparam sval_t Gravity   = sval_t'(GRAVITY);
    localparam sval_t WalkStep  = sval_t'(WALK_STEP);
    localparam sval_t ChargeMax = sval_t'(CHARGE_MAX);
    localparam sval_t JumpVx    = sval_t'(JUMP_VX);

    typedef enum logic [1:0] {
        StGround = 2'd0,
        StCharge = 2'd1,
        StAir    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            tick_q;
    sval_t           x_q, x_d;
    sval_t           y_q, y_d;
    sval_t           vx_q, vx_d;
    sval_t           vy_q, vy_d;
    sval_t           charge_q, charge_d;
    sval_t           dir_latch_q, dir_latch_d;

    sval_t           dir;
    sval_t           x_walk;
    sval_t           y_next;
    sval_t           x_next;
    logic            hit_ceil;
    logic            landing;

    // ------------------------------------------------------------------
    // Tick generator: tick is registered, so it is high in the cycle after
    // the counter reaches TICK_DIV-1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_q == CntMax);
            cnt_q  <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StGround;
            x_q         <= XInit;
            y_q         <= GroundY;
            vx_q        <= '0;
            vy_q        <= '0;
            charge_q    <= '0;
            dir_latch_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            charge_q    <= charge_d;
            dir_latch_q <= dir_latch_d;
        end
    end

    // ------------------------------------------------------------------
    // Shared arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        dir = '0;
        if (key_left && !key_right) begin
            dir = -sval_t'(1);
        end else if (key_right && !key_left) begin
            dir = sval_t'(1);
        end

        x_walk = x_q + dir * WalkStep;

        // Airborne step: vertical first, and the ceiling takes priority over landing.
        y_next   = y_q - vy_q;
        hit_ceil = (y_next < YMin);
        landing  = !hit_ceil && (y_next >= GroundY);
        x_next   = x_q + vx_q;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (tick_q) begin
            unique case (state_q)
                StGround: if (key_space)  state_d = StCharge;
                StCharge: if (!key_space) state_d = StAir;
                StAir:    if (landing)    state_d = StGround;
                default:  state_d = StGround;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Position / velocity / charge next values
    // ------------------------------------------------------------------
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        charge_d    = charge_q;
        dir_latch_d = dir_latch_q;

        if (tick_q) begin
            unique case (state_q)
                StGround: begin
                    y_d = GroundY;
                    if (key_space) begin
                        // Charging starts at 1, and the player does not walk on this tick.
                        charge_d    = sval_t'(1);
                        dir_latch_d = dir;
                    end else if (x_walk < XMin) begin
                        x_d = XMin;
                    end else if (x_walk > XMax) begin
                        x_d = XMax;
                    end else begin
                        x_d = x_walk;
                    end
                end

                StCharge: begin
                    if (key_space) begin
                        charge_d    = (charge_q >= ChargeMax) ? ChargeMax : charge_q + sval_t'(1);
                        dir_latch_d = dir;
                    end else begin
                        vy_d     = charge_q;
                        vx_d     = dir_latch_q * JumpVx;
                        charge_d = '0;
                    end
                end

                StAir: begin
                    if (hit_ceil) begin
                        y_d  = YMin;
                        vy_d = '0;
                    end else if (landing) begin
                        y_d  = GroundY;
                        vy_d = '0;
                    end else begin
                        y_d  = y_next;
                        vy_d = vy_q - Gravity;
                    end

                    if (x_next < XMin) begin
                        x_d  = XMin;
                        vx_d = -vx_q;
                    end else if (x_next > XMax) begin
                        x_d  = XMax;
                        vx_d = -vx_q;
                    end else begin
                        x_d = x_next;
                    end

                    // Landing stops horizontal motion even if a wall was hit this tick.
                    if (landing) begin
                        vx_d = '0;
                    end
                end

                default: begin
                    charge_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [31:0] charge_ext;

    always_comb begin
        charge_ext   = 32'(unsigned'(charge_q));
        value_x      = x_q[W-1:0];
        value_y      = y_q[W-1:0];
        state        = state_q;
        charge_level = charge_ext[7:0];
        tick         = tick_q;
    end

endmodule
